// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array sequencer.
// FSM encoding, operand width and cell-to-done-bit mapping.
package systolic_pkg;

    localparam int DW = 8;
    localparam logic [DW-1:0] FP_ZERO = 8'h00;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_GUARD,
        S_WAIT,
        S_RELEASE,
        S_NEXT,
        S_FIN,
        S_ERR
    } state_e;

    function automatic int cell_idx(input int i, input int j, input int n);
        return i * n + j;
    endfunction

endpackage

// File: rtl/systolic_ctrl_if.sv
// Host buffer/control port plus array edge and handshake signals.
// slave = sequencer side, master = host/array side.
interface systolic_ctrl_if #(
    parameter int N     = 4,
    parameter int K_MAX = 16
);
    import systolic_pkg::*;

    localparam int KW = $clog2(K_MAX);

    logic            wr_en;
    logic            wr_sel;
    logic [KW-1:0]   wr_row;
    logic [KW-1:0]   wr_col;
    logic [DW-1:0]   wr_data;
    logic [KW:0]     k_len;
    logic            start;
    logic            busy;
    logic            done;
    logic            error;
    logic            mac_st;
    logic [N*DW-1:0] row_data;
    logic [N*DW-1:0] col_data;
    logic [N*N-1:0]  mac_done;

    modport slave (
        input  wr_en, wr_sel, wr_row, wr_col, wr_data,
        input  k_len, start, mac_done,
        output busy, done, error, mac_st, row_data, col_data
    );

    modport master (
        output wr_en, wr_sel, wr_row, wr_col, wr_data,
        output k_len, start, mac_done,
        input  busy, done, error, mac_st, row_data, col_data
    );

endinterface

// File: rtl/systolic_skew_feed.sv
// Operand buffers A (N x K_MAX) and B (K_MAX x N) with skewed
// edge selection per wave; edge data is registered on load_i.
module systolic_skew_feed
    import systolic_pkg::*;
#(
    parameter int N     = 4,
    parameter int K_MAX = 16,
    parameter int WW    = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en_i,
    input  logic                     wr_sel_i,
    input  logic [$clog2(K_MAX)-1:0] wr_row_i,
    input  logic [$clog2(K_MAX)-1:0] wr_col_i,
    input  logic [DW-1:0]            wr_data_i,
    input  logic                     load_i,
    input  logic [WW-1:0]            wave_i,
    input  logic [$clog2(K_MAX):0]   k_i,
    output logic [N*DW-1:0]          row_data_o,
    output logic [N*DW-1:0]          col_data_o
);

    logic [DW-1:0]   a_q [N][K_MAX];
    logic [DW-1:0]   b_q [K_MAX][N];
    logic [N*DW-1:0] row_d, col_d;
    logic [N*DW-1:0] row_q, col_q;

    // Address decode; indices outside the buffer shape match nothing
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < K_MAX; k++) begin
                    if (!wr_sel_i && int'(wr_row_i) == i && int'(wr_col_i) == k)
                        a_q[i][k] <= wr_data_i;
                    if (wr_sel_i && int'(wr_row_i) == k && int'(wr_col_i) == i)
                        b_q[k][i] <= wr_data_i;
                end
            end
        end
    end

    // Lane i of wave w carries inner index k = w - i when 0 <= k < K
    always_comb begin
        row_d = {N{FP_ZERO}};
        col_d = {N{FP_ZERO}};
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < K_MAX; k++) begin
                if ((int'(wave_i) - i == k) && (k < int'(k_i))) begin
                    row_d[i*DW +: DW] = a_q[i][k];
                    col_d[i*DW +: DW] = b_q[k][i];
                end
            end
        end
    end

    // Hold edge data from LOAD until the next wave's LOAD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else if (load_i) begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_data_o = row_q;
    assign col_data_o = col_q;

endmodule

// File: rtl/systolic_ctrl.sv
// Wave sequencer for an N x N FP8 systolic array: skewed edge feed,
// shared stMAC/done 4-phase handshake, done-watchdog and host status.
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int N       = 4,
    parameter int K_MAX   = 16,
    parameter int TIMEOUT = 255
) (
    input logic          clk,
    input logic          rst_n,
    systolic_ctrl_if.slave bus
);

    localparam int KW = $clog2(K_MAX);
    localparam int WW = $clog2(K_MAX + 2 * N);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef logic [KW:0]   klen_t;
    typedef logic [WW-1:0] wave_t;
    typedef logic [TW-1:0] wdog_t;

    state_e state_q, state_d;
    wave_t  wave_q, wave_d;
    klen_t  k_q, k_d, k_clamp;
    wdog_t  wdog_q, wdog_d;
    logic   ph_q, ph_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;
    logic   err_q, err_d;
    logic   st_q, st_d;
    logic   all_done, last_wave, load, accept;

    // Clamp the requested inner dimension to the buffer depth
    always_comb begin
        k_clamp = (bus.k_len > klen_t'(K_MAX)) ? klen_t'(K_MAX) : bus.k_len;
    end

    // Every cell must report done before a wave can be released
    always_comb begin
        all_done = 1'b1;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                all_done = all_done & bus.mac_done[cell_idx(i, j, N)];
    end

    assign last_wave = (wave_q + wave_t'(1)) == (wave_t'(k_q) + wave_t'(2 * N - 2));

    // Next-state logic and registered-output decode
    always_comb begin
        state_d = state_q;
        wave_d  = wave_q;
        k_d     = k_q;
        wdog_d  = wdog_q;
        ph_d    = ph_q;
        load    = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    k_d     = k_clamp;
                    wave_d  = '0;
                    state_d = (k_clamp == '0) ? S_FIN : S_LOAD;
                end
            end
            S_LOAD: begin
                load    = 1'b1;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                ph_d    = 1'b0;
                state_d = S_GUARD;
            end
            S_GUARD: begin
                ph_d = ~ph_q;
                if (ph_q) begin
                    wdog_d  = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (all_done)
                    state_d = S_RELEASE;
                else if (wdog_q == wdog_t'(TIMEOUT))
                    state_d = S_ERR;
                else
                    wdog_d = wdog_q + wdog_t'(1);
            end
            S_RELEASE: begin
                ph_d = ~ph_q;
                if (ph_q)
                    state_d = S_NEXT;
            end
            S_NEXT: begin
                if (last_wave) begin
                    state_d = S_FIN;
                end else begin
                    wave_d  = wave_q + wave_t'(1);
                    state_d = S_LOAD;
                end
            end
            S_FIN:   state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        st_d   = (state_d == S_GUARD) || (state_d == S_WAIT);
        busy_d = !(state_d inside {S_IDLE, S_FIN, S_ERR});
        done_d = (state_d == S_FIN);
        err_d  = (state_d == S_ERR) || (err_q && !accept);
    end

    // State, counters and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wave_q  <= '0;
            k_q     <= '0;
            wdog_q  <= '0;
            ph_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            st_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wave_q  <= wave_d;
            k_q     <= k_d;
            wdog_q  <= wdog_d;
            ph_q    <= ph_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            st_q    <= st_d;
        end
    end

    systolic_skew_feed #(
        .N     (N),
        .K_MAX (K_MAX),
        .WW    (WW)
    ) u_feed (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en_i    (bus.wr_en && !busy_q),
        .wr_sel_i   (bus.wr_sel),
        .wr_row_i   (bus.wr_row),
        .wr_col_i   (bus.wr_col),
        .wr_data_i  (bus.wr_data),
        .load_i     (load),
        .wave_i     (wave_q),
        .k_i        (k_q),
        .row_data_o (bus.row_data),
        .col_data_o (bus.col_data)
    );

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.error  = err_q;
    assign bus.mac_st = st_q;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Randomized bench for systolic_ctrl with a cell-array handshake model
// and a matrix-level model of the expected skewed edge operands.
module tb_systolic_ctrl;

    localparam int N  = 4;
    localparam int KM = 16;
    localparam int TO = 10;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    systolic_ctrl_if #(.N(N), .K_MAX(KM)) bus();

    systolic_ctrl #(
        .N       (N),
        .K_MAX   (KM),
        .TIMEOUT (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0]     a_m [N][KM];
    logic [7:0]     b_m [KM][N];
    int             n_cmp = 0;
    int             n_err = 0;
    int             lat = 3;
    logic [N*N-1:0] stuck = '0;
    int             ccnt;

    // Cells: keep old done until stMAC seen, drop it, raise after lat
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mac_done <= '1;
            ccnt <= 0;
        end else if (bus.mac_st) begin
            if (ccnt == 1)
                bus.mac_done <= '0;
            else if (ccnt == lat)
                bus.mac_done <= ~stuck;
            ccnt <= ccnt + 1;
        end else begin
            ccnt <= 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N*8-1:0] exp_row(input int w, input int k);
        logic [N*8-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++)
            if (w - i >= 0 && w - i < k) r[i*8 +: 8] = a_m[i][w-i];
        return r;
    endfunction

    function automatic logic [N*8-1:0] exp_col(input int w, input int k);
        logic [N*8-1:0] r;
        r = '0;
        for (int j = 0; j < N; j++)
            if (w - j >= 0 && w - j < k) r[j*8 +: 8] = b_m[w-j][j];
        return r;
    endfunction

    task automatic wr(input bit sel, input int row, input int col,
                      input logic [7:0] d);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = sel;
        bus.wr_row  = 4'(row);
        bus.wr_col  = 4'(col);
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en = 1'b0;
        if (!sel && row < N) a_m[row][col] = d;
        if (sel && col < N) b_m[row][col] = d;
    endtask

    task automatic run(input int klen, input bit wr0, input bit inject);
        int k, wn, w, dones, done_cyc, hi, lowc;
        bit prev, clr;
        logic [7:0] v;
        k  = (klen > KM) ? KM : klen;
        wn = (k > 0) ? k + 2 * N - 2 : 0;
        lat = $urandom_range(2, 6);
        stuck = '0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.k_len = 5'(klen);
        if (wr0) begin
            v = 8'($urandom);
            bus.wr_en = 1'b1; bus.wr_sel = 1'b0;
            bus.wr_row = '0; bus.wr_col = '0; bus.wr_data = v;
            a_m[0][0] = v;
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        chk("err_clr", bus.error, 0);
        w = 0; dones = 0; done_cyc = 0; hi = 0; lowc = 0;
        prev = 0; clr = 0;
        for (int cyc = 1; cyc <= 4000; cyc++) begin
            if (clr) begin
                bus.start = 1'b0; bus.wr_en = 1'b0; clr = 0;
            end
            if (bus.done) begin
                dones++;
                if (dones == 1) done_cyc = cyc;
            end
            if (bus.mac_st) begin
                if (!prev) begin
                    if (w > 0) chk("st_low_gap", lowc >= 3, 1);
                    chk("busy_run", bus.busy, 1);
                    chk("row_data", bus.row_data, exp_row(w, k));
                    chk("col_data", bus.col_data, exp_col(w, k));
                    w++;
                    hi = 0;
                    if (inject && w == 1) begin
                        bus.wr_en = 1'b1; bus.wr_sel = 1'b0;
                        bus.wr_row = '0; bus.wr_col = '0;
                        bus.wr_data = 8'h7F; bus.start = 1'b1;
                        clr = 1;
                    end
                end
                hi++;
            end else begin
                if (prev) begin
                    chk("st_high", hi, lat + 2);
                    chk("row_hold", bus.row_data, exp_row(w - 1, k));
                    chk("col_hold", bus.col_data, exp_col(w - 1, k));
                    lowc = 0;
                end
                lowc++;
            end
            prev = bus.mac_st;
            if (dones > 0 && cyc >= done_cyc + 4) break;
            @(negedge clk);
        end
        chk("waves", w, wn);
        chk("done_cnt", dones, 1);
        chk("busy_end", bus.busy, 0);
        if (k == 0) chk("k0_done_lat", done_cyc, 1);
    endtask

    task automatic run_timeout();
        int r, e, rises, dones;
        bit prev;
        lat = 3;
        stuck = 16'h0020;
        @(negedge clk);
        bus.start = 1'b1;
        bus.k_len = 5'($urandom_range(1, KM));
        @(negedge clk);
        bus.start = 1'b0;
        r = -1; e = -1; rises = 0; dones = 0; prev = 0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            if (bus.done) dones++;
            if (bus.mac_st && !prev) begin
                rises++;
                if (r < 0) r = cyc;
            end
            prev = bus.mac_st;
            if (bus.error && e < 0) begin
                e = cyc;
                chk("to_mac_st", bus.mac_st, 0);
                chk("to_busy", bus.busy, 0);
            end
            if (e >= 0 && cyc >= e + 4) break;
            @(negedge clk);
        end
        chk("to_latency", e - r, 13);
        chk("to_rises", rises, 1);
        chk("to_done", dones, 0);
        chk("to_err_hold", bus.error, 1);
        stuck = '0;
    endtask

    task automatic run_reset();
        int act;
        lat = 3;
        stuck = 16'h0001;
        @(negedge clk);
        bus.start = 1'b1;
        bus.k_len = 5'd6;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c < 50 && !bus.mac_st; c++) @(negedge clk);
        chk("rst_reach", bus.mac_st, 1);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_ctl", {bus.busy, bus.done, bus.error, bus.mac_st}, 0);
        chk("rst_row", bus.row_data, 0);
        chk("rst_col", bus.col_data, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stuck = '0;
        act = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done || bus.mac_st || bus.busy) act++;
        end
        chk("rst_quiet", act, 0);
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_row = '0;
        bus.wr_col = '0; bus.wr_data = '0; bus.k_len = '0;
        bus.start = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("init_ctl", {bus.busy, bus.done, bus.error, bus.mac_st}, 0);
        chk("init_row", bus.row_data, 0);
        chk("init_col", bus.col_data, 0);

        for (int i = 0; i < N; i++)
            for (int k = 0; k < KM; k++) wr(0, i, k, 8'($urandom));
        for (int k = 0; k < KM; k++)
            for (int j = 0; j < N; j++) wr(1, k, j, 8'($urandom));
        repeat (4) begin
            wr(0, $urandom_range(N, 15), $urandom_range(0, 15), 8'($urandom));
            wr(1, $urandom_range(0, 15), $urandom_range(N, 15), 8'($urandom));
        end

        wr(0, 0, 0, 8'h11); wr(0, 0, 1, 8'h12);
        wr(0, 1, 0, 8'h21); wr(0, 1, 1, 8'h22);
        wr(1, 0, 0, 8'h31); wr(1, 0, 1, 8'h32);
        wr(1, 1, 0, 8'h41); wr(1, 1, 1, 8'h42);
        run(2, 0, 0);
        run(0, 0, 0);
        run(20, 0, 0);

        repeat (5) begin
            repeat (3) wr($urandom_range(0, 1), $urandom_range(0, 3),
                          $urandom_range(0, 3), 8'($urandom));
            run($urandom_range(1, KM), 1'($urandom_range(0, 1)), 0);
        end

        run(5, 0, 1);
        run(3, 0, 0);
        run_timeout();
        run(4, 0, 0);
        run_reset();
        run(6, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL sim_timeout: got no finish, required finish");
        $fatal(1);
    end

endmodule
